// File: rtl/grover_oracle_ctrl.sv
// grover_oracle_ctrl: register file and sequencer for the 8-state Grover datapath.
// Loads a uniform superposition, applies the phase-flip oracle, captures the
// external inversion-about-mean stage K times, then scans for argmax |amp|.
// Build option: define GROVER_ORACLE_SAT_EN to saturate the oracle negation
// of the most negative amplitude (-128 -> +127); otherwise it wraps.
module grover_oracle_ctrl #(
  parameter int NUM_BIT  = 3,
  parameter int AMP_W    = 8,
  parameter int INIT_AMP = 45,
  parameter int ITER_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_BIT-1:0]   target,
  input  logic [ITER_W-1:0]    num_iter,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_BIT-1:0]   result,
  output logic [AMP_W-1:0]     result_amp,
  output logic [AMP_W-1:0]     d_o0,
  output logic [AMP_W-1:0]     d_o1,
  output logic [AMP_W-1:0]     d_o2,
  output logic [AMP_W-1:0]     d_o3,
  output logic [AMP_W-1:0]     d_o4,
  output logic [AMP_W-1:0]     d_o5,
  output logic [AMP_W-1:0]     d_o6,
  output logic [AMP_W-1:0]     d_o7,
  input  logic [AMP_W-1:0]     d_i0,
  input  logic [AMP_W-1:0]     d_i1,
  input  logic [AMP_W-1:0]     d_i2,
  input  logic [AMP_W-1:0]     d_i3,
  input  logic [AMP_W-1:0]     d_i4,
  input  logic [AMP_W-1:0]     d_i5,
  input  logic [AMP_W-1:0]     d_i6,
  input  logic [AMP_W-1:0]     d_i7
);

  localparam int unsigned NUM_AMP = 2 ** NUM_BIT;
  localparam logic [NUM_BIT-1:0] LAST_IDX = NUM_BIT'(NUM_AMP - 1);
  localparam logic signed [AMP_W-1:0] AMP_MIN = {1'b1, {(AMP_W-1){1'b0}}};
  localparam logic signed [AMP_W-1:0] AMP_MAX = {1'b0, {(AMP_W-1){1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ORACLE,
    S_DIFFUSE,
    S_MEASURE,
    S_DONE
  } state_t;

  state_t                    state;
  logic signed [AMP_W-1:0]   amp [NUM_AMP];
  logic signed [AMP_W-1:0]   din [NUM_AMP];
  logic [NUM_BIT-1:0]        target_q;
  logic [ITER_W-1:0]         iter_k;
  logic [ITER_W-1:0]         iter_cnt;
  logic [NUM_BIT-1:0]        scan_idx;
  logic [NUM_BIT-1:0]        best_idx;
  logic [AMP_W:0]            best_mag;
  logic signed [AMP_W-1:0]   best_amp;

  logic signed [AMP_W-1:0]   amp_tgt;
  logic signed [AMP_W-1:0]   amp_neg;
  logic signed [AMP_W-1:0]   cur_amp;
  logic signed [AMP_W:0]     cur_ext;
  logic [AMP_W:0]            cur_mag;
  logic                      take;
  logic [NUM_BIT-1:0]        sel_idx;
  logic [AMP_W:0]            sel_mag;
  logic signed [AMP_W-1:0]   sel_amp;

  // Amplitudes go out to, and come back from, the inversion stage unchanged
  assign d_o0 = amp[0];
  assign d_o1 = amp[1];
  assign d_o2 = amp[2];
  assign d_o3 = amp[3];
  assign d_o4 = amp[4];
  assign d_o5 = amp[5];
  assign d_o6 = amp[6];
  assign d_o7 = amp[7];

  assign din[0] = $signed(d_i0);
  assign din[1] = $signed(d_i1);
  assign din[2] = $signed(d_i2);
  assign din[3] = $signed(d_i3);
  assign din[4] = $signed(d_i4);
  assign din[5] = $signed(d_i5);
  assign din[6] = $signed(d_i6);
  assign din[7] = $signed(d_i7);

  // Oracle phase flip of the marked amplitude
  assign amp_tgt = amp[target_q];
`ifdef GROVER_ORACLE_SAT_EN
  assign amp_neg = (amp_tgt == AMP_MIN) ? AMP_MAX : AMP_W'(-amp_tgt);
`else
  assign amp_neg = AMP_W'(-amp_tgt);
`endif

  // Measurement compare: 9-bit magnitude so |-128| = 128, ties keep lower index
  assign cur_amp = amp[scan_idx];
  assign cur_ext = {cur_amp[AMP_W-1], cur_amp};
  assign cur_mag = cur_ext[AMP_W] ? (AMP_W+1)'(-cur_ext) : (AMP_W+1)'(cur_ext);
  assign take    = (scan_idx == '0) || (cur_mag > best_mag);
  assign sel_idx = take ? scan_idx : best_idx;
  assign sel_mag = take ? cur_mag  : best_mag;
  assign sel_amp = take ? cur_amp  : best_amp;

  // Sequencer and register file
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      result_amp <= '0;
      target_q   <= '0;
      iter_k     <= '0;
      iter_cnt   <= '0;
      scan_idx   <= '0;
      best_idx   <= '0;
      best_mag   <= '0;
      best_amp   <= '0;
      for (int i = 0; i < NUM_AMP; i++) amp[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            target_q <= target;
            iter_k   <= num_iter;
            busy     <= 1'b1;
            state    <= S_INIT;
          end
        end
        S_INIT: begin
          for (int i = 0; i < NUM_AMP; i++) amp[i] <= AMP_W'(INIT_AMP);
          iter_cnt <= '0;
          scan_idx <= '0;
          state    <= (iter_k != '0) ? S_ORACLE : S_MEASURE;
        end
        S_ORACLE: begin
          amp[target_q] <= amp_neg;
          state         <= S_DIFFUSE;
        end
        S_DIFFUSE: begin
          for (int i = 0; i < NUM_AMP; i++) amp[i] <= din[i];
          iter_cnt <= iter_cnt + ITER_W'(1);
          state    <= ((iter_cnt + ITER_W'(1)) == iter_k) ? S_MEASURE : S_ORACLE;
        end
        S_MEASURE: begin
          best_idx <= sel_idx;
          best_mag <= sel_mag;
          best_amp <= sel_amp;
          scan_idx <= scan_idx + NUM_BIT'(1);
          if (scan_idx == LAST_IDX) begin
            result     <= sel_idx;
            result_amp <= sel_amp;
            done       <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grover_oracle_ctrl.sv
// Directed bench for grover_oracle_ctrl with a behavioural inversion-about-mean stage.
module tb_grover_oracle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] target;
  logic [3:0] num_iter;
  logic       busy;
  logic       done;
  logic [2:0] result;
  logic [7:0] result_amp;
  logic [7:0] d_o0, d_o1, d_o2, d_o3, d_o4, d_o5, d_o6, d_o7;
  logic [7:0] d_i0, d_i1, d_i2, d_i3, d_i4, d_i5, d_i6, d_i7;

  logic signed [7:0] dov [8];
  logic signed [7:0] dinv [8];
  logic              force5;
  int                msum;
  int                mtm;

  int checks = 0;
  int errors = 0;

  grover_oracle_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .target(target), .num_iter(num_iter),
    .busy(busy), .done(done), .result(result), .result_amp(result_amp),
    .d_o0(d_o0), .d_o1(d_o1), .d_o2(d_o2), .d_o3(d_o3),
    .d_o4(d_o4), .d_o5(d_o5), .d_o6(d_o6), .d_o7(d_o7),
    .d_i0(d_i0), .d_i1(d_i1), .d_i2(d_i2), .d_i3(d_i3),
    .d_i4(d_i4), .d_i5(d_i5), .d_i6(d_i6), .d_i7(d_i7)
  );

  always #5 clk = ~clk;

  assign dov[0] = d_o0;
  assign dov[1] = d_o1;
  assign dov[2] = d_o2;
  assign dov[3] = d_o3;
  assign dov[4] = d_o4;
  assign dov[5] = d_o5;
  assign dov[6] = d_o6;
  assign dov[7] = d_o7;

  // Inversion about the mean: out = floor(2*mean) - a, wrapped to 8 bits
  always_comb begin
    msum = 0;
    for (int i = 0; i < 8; i++) msum = msum + int'(dov[i]);
    mtm = msum >>> 2;
    for (int i = 0; i < 8; i++) dinv[i] = 8'(mtm - int'(dov[i]));
  end

  assign d_i0 = dinv[0];
  assign d_i1 = dinv[1];
  assign d_i2 = dinv[2];
  assign d_i3 = dinv[3];
  assign d_i4 = dinv[4];
  assign d_i5 = force5 ? 8'h80 : dinv[5];
  assign d_i6 = dinv[6];
  assign d_i7 = dinv[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; returns 1 time unit after the accepting edge
  task automatic do_start(input logic [2:0] t, input logic [3:0] k);
    start    = 1'b1;
    target   = t;
    num_iter = k;
    tick();
    start    = 1'b0;
  endtask

  // Counts edges after the accepting edge until done; -1 on timeout
  task automatic wait_done(output int lat);
    int n;
    lat = -1;
    n = 0;
    while (lat < 0 && n < 60) begin
      tick();
      n++;
      if (done === 1'b1) lat = n;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; target = '0; num_iter = '0; force5 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0d want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0d want 0", done); end
    checks++; if (result !== 3'd0) begin errors++; $display("FAIL reset_result got %0d want 0", result); end
    checks++; if (result_amp !== 8'd0) begin errors++; $display("FAIL reset_result_amp got %0d want 0", result_amp); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dov[i] !== 8'sd0) begin errors++; $display("FAIL reset_d_o%0d got %0d want 0", i, dov[i]); end
    end
  endtask

  task automatic test_k2_target5();
    logic signed [7:0] exp;
    do_start(3'd5, 4'd2);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL k2_busy got %0d want 1", busy); end
    tick(); tick(); tick();
    for (int i = 0; i < 8; i++) begin
      exp = (i == 5) ? 8'sd112 : 8'sd22;
      checks++;
      if (dov[i] !== exp) begin errors++; $display("FAIL k2_iter1_amp%0d got %0d want %0d", i, dov[i], exp); end
    end
    tick(); tick();
    for (int i = 0; i < 8; i++) begin
      exp = (i == 5) ? 8'sd122 : -8'sd12;
      checks++;
      if (dov[i] !== exp) begin errors++; $display("FAIL k2_iter2_amp%0d got %0d want %0d", i, dov[i], exp); end
    end
    for (int n = 6; n <= 12; n++) tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL k2_done_early got %0d want 0", done); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL k2_done_e13 got %0d want 1", done); end
    checks++; if (result !== 3'd5) begin errors++; $display("FAIL k2_result got %0d want 5", result); end
    checks++; if ($signed(result_amp) !== 8'sd122) begin errors++; $display("FAIL k2_result_amp got %0d want 122", $signed(result_amp)); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL k2_done_pulse got %0d want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL k2_busy_end got %0d want 0", busy); end
  endtask

  task automatic test_reset_mid();
    do_start(3'd1, 4'd5);
    for (int n = 0; n < 6; n++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %0d want 0", busy); end
    checks++; if (result !== 3'd0) begin errors++; $display("FAIL mid_reset_result got %0d want 0", result); end
    checks++; if (result_amp !== 8'd0) begin errors++; $display("FAIL mid_reset_result_amp got %0d want 0", result_amp); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dov[i] !== 8'sd0) begin errors++; $display("FAIL mid_reset_d_o%0d got %0d want 0", i, dov[i]); end
    end
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_idle_busy got %0d want 0", busy); end
    end
  endtask

  task automatic test_k3_target2();
    int lat;
    logic signed [7:0] exp;
    do_start(3'd2, 4'd3);
    wait_done(lat);
    checks++; if (lat != 15) begin errors++; $display("FAIL k3_latency got %0d want 15", lat); end
    checks++; if (result !== 3'd2) begin errors++; $display("FAIL k3_result got %0d want 2", result); end
    checks++; if ($signed(result_amp) !== 8'sd70) begin errors++; $display("FAIL k3_result_amp got %0d want 70", $signed(result_amp)); end
    for (int i = 0; i < 8; i++) begin
      exp = (i == 2) ? 8'sd70 : -8'sd40;
      checks++;
      if (dov[i] !== exp) begin errors++; $display("FAIL k3_amp%0d got %0d want %0d", i, dov[i], exp); end
    end
    tick();
  endtask

  task automatic test_k0_tie();
    int lat;
    do_start(3'd6, 4'd0);
    wait_done(lat);
    checks++; if (lat != 9) begin errors++; $display("FAIL k0_latency got %0d want 9", lat); end
    checks++; if (result !== 3'd0) begin errors++; $display("FAIL k0_result got %0d want 0", result); end
    checks++; if ($signed(result_amp) !== 8'sd45) begin errors++; $display("FAIL k0_result_amp got %0d want 45", $signed(result_amp)); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dov[i] !== 8'sd45) begin errors++; $display("FAIL k0_amp%0d got %0d want 45", i, dov[i]); end
    end
    tick();
  endtask

  task automatic test_ignore_start();
    int lat;
    int pulses;
    do_start(3'd3, 4'd1);
    start = 1'b1; target = 3'd6; num_iter = 4'd0;
    tick(); tick(); tick();
    start = 1'b0;
    lat = -1;
    pulses = 0;
    for (int n = 4; n <= 34; n++) begin
      tick();
      start = 1'b0;
      if (done === 1'b1) begin
        pulses++;
        if (lat < 0) begin
          lat = n;
          checks++; if (result !== 3'd3) begin errors++; $display("FAIL ign_result got %0d want 3", result); end
          checks++; if ($signed(result_amp) !== 8'sd112) begin errors++; $display("FAIL ign_result_amp got %0d want 112", $signed(result_amp)); end
          start = 1'b1; target = 3'd6; num_iter = 4'd0;
        end
      end
    end
    checks++; if (lat != 11) begin errors++; $display("FAIL ign_latency got %0d want 11", lat); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL ign_done_pulses got %0d want 1", pulses); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy_end got %0d want 0", busy); end
    checks++; if (result !== 3'd3) begin errors++; $display("FAIL ign_result_held got %0d want 3", result); end
  endtask

  task automatic test_oracle_min();
    int lat;
    logic signed [7:0] exp5;
`ifdef GROVER_ORACLE_SAT_EN
    exp5 = 8'sd127;
`else
    exp5 = -8'sd128;
`endif
    do_start(3'd5, 4'd2);
    tick(); tick();
    force5 = 1'b1;
    tick();
    force5 = 1'b0;
    checks++; if (dov[5] !== -8'sd128) begin errors++; $display("FAIL sat_capture_d_o5 got %0d want -128", dov[5]); end
    tick();
    checks++; if (dov[5] !== exp5) begin errors++; $display("FAIL sat_oracle_d_o5 got %0d want %0d", dov[5], exp5); end
    checks++; if (dov[4] !== 8'sd22) begin errors++; $display("FAIL sat_other_d_o4 got %0d want 22", dov[4]); end
    wait_done(lat);
    checks++; if (lat != 9) begin errors++; $display("FAIL sat_latency_rest got %0d want 9", lat); end
    tick();
  endtask

  initial begin
    test_reset();
    test_k2_target5();
    test_reset_mid();
    test_k3_target2();
    test_k0_tie();
    test_ignore_start();
    test_oracle_min();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/grover_oracle_ctrl.md
Name: grover_oracle_ctrl

Overview:
- Sequential front/back end of the 8-state Grover amplitude datapath.
- Holds the 8 signed amplitudes in registers and initialises them to uniform superposition.
- Applies the phase-flip oracle to the target index, drives the amplitudes into the combinational inversion-about-mean stage and captures its outputs, repeating for a programmed iteration count.
- Finally scans the register file and reports the index with the largest magnitude as the measured result.

Parameters:
- NUM_BIT, 3, index width; number of amplitudes = 2**NUM_BIT = 8 (fixed at 8 ports)
- AMP_W, 8, amplitude width, signed Q0.7 (value = amp/128)
- INIT_AMP, 45, reset/initial amplitude (≈1/sqrt(8) in Q0.7)
- ITER_W, 4, width of iteration count

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a search; sampled only in IDLE
- target  input  3  marked index; latched on accepted start
- num_iter  input  4  Grover iteration count K; latched on accepted start
- busy  output  1  high from the cycle after accepted start until DONE inclusive
- done  output  1  one-cycle pulse, result valid
- result  output  3  measured index (argmax |amp|); held until next accepted start
- result_amp  output  8  signed amplitude at result index; held likewise
- d_o0..d_o7  output  8 each  amplitudes to inversion stage; combinational copy of amp regs 0..7
- d_i0..d_i7  input  8 each  inverted amplitudes returned from inversion stage, same cycle

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-search): state=IDLE; amp regs, d_o*, result, result_amp, iteration counter and scan index all 0; busy=0, done=0.
- FSM states: IDLE, INIT, ORACLE, DIFFUSE, MEASURE, DONE.
- IDLE: start=1 at edge E0 latches target/num_iter -> INIT. start in any other state is ignored.
- INIT (E1): all amp regs <= INIT_AMP; iter counter <= 0; next ORACLE if K>0, else MEASURE.
- ORACLE (1 cycle): amp[target] <= -amp[target]; other regs unchanged -> DIFFUSE.
- DIFFUSE (1 cycle): amp[i] <= d_i[i] for all i; counter++ ; counter+1==K -> MEASURE, else ORACLE.
- Each iteration costs exactly 2 cycles; the inversion stage is purely combinational with no wait.
- MEASURE (8 cycles): scan index 0..7.
  - Index 0 loads best; each later index replaces best only if |amp| is strictly greater.
  - Ties go to the lowest index.
  - Magnitude is computed at 9 bits, so |-128| = 128.
- After index 7 -> DONE: done=1 and result/result_amp valid for one cycle -> IDLE.
- Latency: done is high in the cycle following edge E0+2K+9. K=0 gives 9; K=2 gives 13.
- Amp regs hold their final values after DONE and reset to INIT_AMP on the next start.
- start asserted in the DONE cycle is ignored; it is accepted in the following IDLE cycle.
- Counter wrap: K=15 is legal; the counter compares equality only, so it never wraps.
- Oracle negation of -128: see macro below.

Optional Feature:
- Macro GROVER_ORACLE_SAT_EN.
  - Defined: oracle negation saturates, so -(-128) gives +127.
  - Undefined: two's-complement wrap, so -(-128) stays -128, matching the inversion stage's wrap behaviour.
- All other behaviour is identical in both builds.

Test Plan:
- Reset mid-search (rst in the 3rd DIFFUSE cycle) -> next cycle busy=0, d_o*=0, result=0; a fresh start then runs normally.
- target=5, K=2 with the real inversion stage -> after iteration 1 amps are 22 except amp5=112; after iteration 2 amps are -12 except amp5=122. done at E0+13, result=5, result_amp=122.
- target=2, K=3 -> final amps are -40 except amp2=70; result=2, result_amp=70; done at E0+15.
- K=0, target=6 -> all amps 45, result=0 (tie goes to lowest index), result_amp=45, done at E0+9.
- start pulses while busy, and in the DONE cycle -> ignored, no change in latched target; a single done pulse per accepted start.
- Force d_i5=-128 at the capture before the final oracle, target=5:
  - GROVER_ORACLE_SAT_EN defined -> amp5=127 after the oracle.
  - Undefined -> amp5=-128.
  - Check d_o5 in the DIFFUSE cycle for both builds.
